// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display encoder.
// The BCD_ENCODER_SATURATE_EN build option is consumed in bcd_encoder.sv.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } bcd_state_e;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned HUND_W        = 2;
    localparam int unsigned NUM_DIGITS    = 3;
    localparam int unsigned SCRATCH_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned MAX_VALUE_DEF = 299;

    // Double-dabble correction: a digit that will reach 10 or more after the
    // next doubling is pre-biased by 3 so the carry lands in the next digit.
    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] digit);
        return (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;
    endfunction

endpackage

// File: rtl/bcd_encoder_if.sv
// Request/result bundle between an ALU-side master and the BCD encoder.
// master drives the operand and start; slave returns digits and flags.
interface bcd_encoder_if
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH = 9
);

    logic               start;
    logic [WIDTH-1:0]   Value;
    logic               OvfIn;
    logic               busy;
    logic               done;
    logic [DIGIT_W-1:0] Units;
    logic [DIGIT_W-1:0] Tens;
    logic [HUND_W-1:0]  Hundreds;
    logic               Zero;
    logic               Overflow;
    logic [1:0]         state;

    modport master (
        output start, Value, OvfIn,
        input  busy, done, Units, Tens, Hundreds, Zero, Overflow, state
    );

    modport slave (
        input  start, Value, OvfIn,
        output busy, done, Units, Tens, Hundreds, Zero, Overflow, state
    );

endinterface

// File: rtl/bcd_add3.sv
// One scratch-digit correction stage of the shift-add-3 converter.
// Adds 3 to the digit when it is 5 or more, otherwise passes it through.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = add3(i_digit);

endmodule

// File: rtl/bcd_encoder.sv
// Sequential binary-to-BCD converter (shift-add-3) for a 3-digit display.
// Define BCD_ENCODER_SATURATE_EN to show 2,9,9 on overflow instead of 0,0,0.
module bcd_encoder
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned MAX_VALUE = MAX_VALUE_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_encoder_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    bcd_state_e           r_fsm;
    logic [WIDTH-1:0]     r_sr;
    logic [SCRATCH_W-1:0] r_scratch;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_cap;
    logic                 r_zero_cap;
    logic                 r_busy;
    logic                 r_done;
    logic [DIGIT_W-1:0]   r_units;
    logic [DIGIT_W-1:0]   r_tens;
    logic [HUND_W-1:0]    r_hund;
    logic                 r_zero;
    logic                 r_ovf;
    logic [1:0]           r_state;

    logic [SCRATCH_W-1:0] w_adj;
    logic                 w_ovf_in;
    logic                 w_zero_in;
    logic [DIGIT_W-1:0]   w_res_units;
    logic [DIGIT_W-1:0]   w_res_tens;
    logic [HUND_W-1:0]    w_res_hund;
    logic                 w_unused;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Flags are judged on the operand as captured, not on later bus values.
    assign w_ovf_in  = bus.OvfIn | (32'(bus.Value) > MAX_VALUE);
    assign w_zero_in = (bus.Value == '0) & ~w_ovf_in;

    always_comb begin
        w_res_units = r_scratch[0 +: DIGIT_W];
        w_res_tens  = r_scratch[DIGIT_W +: DIGIT_W];
        w_res_hund  = r_scratch[2*DIGIT_W +: HUND_W];
        if (r_ovf_cap) begin
`ifdef BCD_ENCODER_SATURATE_EN
            w_res_units = DIGIT_W'(9);
            w_res_tens  = DIGIT_W'(9);
            w_res_hund  = HUND_W'(2);
`else
            w_res_units = '0;
            w_res_tens  = '0;
            w_res_hund  = '0;
`endif
        end
    end

    // Top hundreds bits are nonzero only for overflowed operands, which are masked.
    assign w_unused = ^{w_adj[SCRATCH_W-1], r_scratch[SCRATCH_W-1 -: (DIGIT_W - HUND_W)]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm      <= StIdle;
            r_sr       <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_cap  <= 1'b0;
            r_zero_cap <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_units    <= '0;
            r_tens     <= '0;
            r_hund     <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_state    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                StIdle: begin
                    if (bus.start) begin
                        r_sr       <= bus.Value;
                        r_scratch  <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_ovf_cap  <= w_ovf_in;
                        r_zero_cap <= w_zero_in;
                        r_busy     <= 1'b1;
                        r_fsm      <= StShift;
                    end
                end
                StShift: begin
                    if (r_cnt != '0) begin
                        r_scratch <= {w_adj[SCRATCH_W-2:0], r_sr[WIDTH-1]};
                        r_sr      <= {r_sr[WIDTH-2:0], 1'b0};
                        r_cnt     <= r_cnt - CNT_W'(1);
                    end else begin
                        r_units <= w_res_units;
                        r_tens  <= w_res_tens;
                        r_hund  <= w_res_hund;
                        r_zero  <= r_zero_cap;
                        r_ovf   <= r_ovf_cap;
                        r_state <= r_state + 2'd1;
                        r_done  <= 1'b1;
                        r_fsm   <= StDone;
                    end
                end
                StDone: begin
                    r_busy <= 1'b0;
                    r_fsm  <= StIdle;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_fsm  <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.Units    = r_units;
    assign bus.Tens     = r_tens;
    assign bus.Hundreds = r_hund;
    assign bus.Zero     = r_zero;
    assign bus.Overflow = r_ovf;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_bcd_encoder.sv
// Self-checking bench for bcd_encoder: directed cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_encoder;

    localparam int unsigned WIDTH = 9;
    localparam int          MAXV  = 299;

    logic clk = 1'b0;
    logic rst_n;
    int   checks    = 0;
    int   errors    = 0;
    int   exp_state = 0;

    always #5 clk = ~clk;

    bcd_encoder_if #(.WIDTH(WIDTH)) bus ();

    bcd_encoder #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAXV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void model(input int v, input bit oi, output int u, output int t,
                                  output int h, output bit z, output bit o);
        o = oi || (v > MAXV);
        z = (v == 0) && !o;
        if (o) begin
`ifdef BCD_ENCODER_SATURATE_EN
            h = 2; t = 9; u = 9;
`else
            h = 0; t = 0; u = 0;
`endif
        end else begin
            u = v % 10;
            t = (v / 10) % 10;
            h = v / 100;
        end
    endfunction

    // Called at a negedge with the DUT idle; returns in cycle 0 with the bus scrambled.
    task automatic do_start(input int v, input bit oi);
        bus.start = 1'b1;
        bus.Value = WIDTH'(v);
        bus.OvfIn = oi;
        @(negedge clk);
        bus.start = 1'b0;
        bus.Value = WIDTH'($urandom_range(0, 511));
        bus.OvfIn = 1'($urandom_range(0, 1));
    endtask

    task automatic run_cycles(input int pa, input int pb, output int first, output int cnt,
                              output bit busy_ok);
        first   = -1;
        cnt     = 0;
        busy_ok = (bus.busy === 1'b1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
            end
            if (bus.busy !== (c <= 10)) busy_ok = 1'b0;
            bus.start = (c == pa) || (c == pb);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.Value = '0;
        bus.OvfIn = 1'b0;
        repeat (2) @(negedge clk);
        obs = {bus.busy, bus.done, bus.Units, bus.Tens, bus.Hundreds, bus.Zero, bus.Overflow,
               bus.state};
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got %h want 0000", obs);
        end
        rst_n = 1'b1;
        exp_state = 0;
        @(negedge clk);
    endtask

    task automatic test_conversion(input string tag, input int v, input bit oi, input int pa,
                                   input int pb);
        int eu, et, eh, first, cnt;
        bit ez, eo, busy_ok;
        model(v, oi, eu, et, eh, ez, eo);
        do_start(v, oi);
        run_cycles(pa, pb, first, cnt, busy_ok);
        exp_state = (exp_state + 1) % 4;
        checks++;
        if (first != 10) begin
            errors++;
            $display("FAIL %s done_cycle v=%0d got %0d want 10", tag, v, first);
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL %s done_count v=%0d got %0d want 1", tag, v, cnt);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy_window v=%0d got bad want high cycles 0..10 only", tag, v);
        end
        checks++;
        if ({bus.Hundreds, bus.Tens, bus.Units} !== {2'(eh), 4'(et), 4'(eu)}) begin
            errors++;
            $display("FAIL %s digits v=%0d ovf=%0d got %0d,%0d,%0d want %0d,%0d,%0d", tag, v, oi,
                     bus.Hundreds, bus.Tens, bus.Units, eh, et, eu);
        end
        checks++;
        if ({bus.Zero, bus.Overflow} !== {ez, eo}) begin
            errors++;
            $display("FAIL %s flags v=%0d ovf=%0d got z%0d o%0d want z%0d o%0d", tag, v, oi,
                     bus.Zero, bus.Overflow, ez, eo);
        end
        checks++;
        if (bus.state !== 2'(exp_state)) begin
            errors++;
            $display("FAIL %s state got %0d want %0d", tag, bus.state, exp_state);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs;
        bit          quiet = 1'b1;
        do_start(200, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {bus.busy, bus.done, bus.Units, bus.Tens, bus.Hundreds, bus.Zero, bus.Overflow,
               bus.state};
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_clear got %h want 0000", obs);
        end
        exp_state = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if ({bus.busy, bus.done, bus.Units, bus.Tens, bus.Hundreds, bus.Zero, bus.Overflow,
                 bus.state} !== 16'h0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_reset_quiet got activity want none");
        end
        test_conversion("post_reset", 7, 1'b0, -1, -1);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            test_conversion("random", int'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0),
                            -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_conversion("zero", 0, 1'b0, -1, -1);
        test_conversion("v123", 123, 1'b0, -1, -1);
        test_conversion("v299", 299, 1'b0, -1, -1);
        test_conversion("v300", 300, 1'b0, -1, -1);
        test_conversion("ovfin", 5, 1'b1, -1, -1);
        test_conversion("start_busy", 42, 1'b0, 3, 10);
        test_reset_mid();
        test_random(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_encoder.md
BCD_ENCODER -- requirements
Module: bcd_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 9, binary operand width.
REQ-002 SHALL have parameter MAX_VALUE, default 299, largest value representable on three display digits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request conversion; sampled only in IDLE.
REQ-007 Value  input  WIDTH  unsigned ALU result; captured on accepted start.
REQ-008 OvfIn  input  1  ALU overflow flag; captured with Value.
REQ-009 busy  output  1  high in SHIFT and DONE.
REQ-010 done  output  1  one-cycle pulse when results update.
REQ-011 Units, Tens  output  4  BCD digits.
REQ-012 Hundreds  output  2  BCD hundreds digit, 0..2.
REQ-013 Zero, Overflow  output  1  result flags.
REQ-014 state  output  2  result sequence count, +1 (mod 4) on every done; display refresh trigger.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT, DONE; IDLE->SHIFT on start, SHIFT->DONE after WIDTH shifts, DONE->IDLE unconditionally.
REQ-016 On accepted start SHALL load Value into shift register, clear 12-bit scratch BCD (3 x 4-bit digits), set shift counter to WIDTH.
REQ-017 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left one bit.
REQ-018 done SHALL be high exactly in cycle WIDTH+1 after start edge (cycle 10 for WIDTH=9).
REQ-019 Units/Tens/Hundreds/Zero/Overflow/state SHALL update only on edge entering DONE and hold until next DONE.
REQ-020 Overflow SHALL be OvfIn | (captured Value > MAX_VALUE).
REQ-021 Zero SHALL be (captured Value == 0) & ~Overflow.
REQ-022 start while busy SHALL be ignored, no queuing; start in DONE cycle ignored.
REQ-023 Value/OvfIn changes after capture SHALL not affect the running conversion.

Reset
REQ-024 rst_n low SHALL force IDLE, busy=0, done=0, digits=0, Zero=0, Overflow=0, state=0, immediately, including mid-SHIFT.
REQ-025 Conversion interrupted by reset SHALL produce no done and no output change after release.

Configuration
REQ-026 With BCD_ENCODER_SATURATE_EN defined, overflow result SHALL output digits 2,9,9.
REQ-027 Without BCD_ENCODER_SATURATE_EN, overflow result SHALL output digits 0,0,0; Overflow flag identical in both builds.

Structure
REQ-028 Package bcd_pkg SHALL hold FSM state encoding, DIGIT_W=4, HUND_W=2, default MAX_VALUE.
REQ-029 Sub-module bcd_add3 (4-bit in, 4-bit out, +3 if >=5) SHALL be instantiated once per scratch digit.
REQ-030 Outputs SHALL be registered; no combinational path input->output.

Verification
REQ-031 Value=0, start -> done at cycle 10, digits 0,0,0, Zero=1, Overflow=0, state 0->1.
REQ-032 Value=123 -> Hundreds=1, Tens=2, Units=3, Zero=0, Overflow=0.
REQ-033 Value=299 -> 2,9,9, Overflow=0; Value=300 -> Overflow=1, digits 2,9,9 (SATURATE_EN) or 0,0,0 (not).
REQ-034 Value=5, OvfIn=1 -> Overflow=1, Zero=0, digits per REQ-026/027.
REQ-035 start pulsed at cycles 3 and 10 of a conversion of 42 -> single done, digits 0,4,2, state +1 only.
REQ-036 rst_n low at cycle 5 of conversion of 200 -> all outputs 0 immediately, no done after release; new start of 7 -> 0,0,7 at cycle 10.
